// File: rtl/fifo_word_packer_if.sv
// rtl/fifo_word_packer_if.sv - FIFO read-side and packed-word stream bundle for fifo_word_packer
// Purpose: groups the FIFO pop handshake, the flush request and the packed output stream.
// Signals:
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     FIFO pop strobe
//   fifo_data_out  FIFO read data, valid the cycle after fifo_rd_en
//   flush          single-cycle request to close the current partial word
//   m_valid        packed word valid
//   m_ready        downstream accept
//   m_data         packed word, first popped byte in the lowest lane
//   m_keep         per-lane byte enables
//   m_last         word was closed by a flush
// Modports: master = packer side, slave = FIFO/downstream side.
interface fifo_word_packer_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int PACK       = 4
);
    localparam int OUT_WIDTH = FIFO_WIDTH * PACK;

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_WIDTH-1:0]  m_data;
    logic [PACK-1:0]       m_keep;
    logic                  m_last;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  flush,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_keep,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output flush,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_keep,
        input  m_last
    );
endinterface

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - pops FIFO bytes and packs PACK of them into one valid/ready output word
// Purpose: read-side consumer of a byte FIFO. Issues back-to-back pops, accumulates bytes into
//          lanes (first byte in lane 0), hands full words to a registered output stage, and closes
//          partial words with keep/last on a flush request.
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   fifo_word_packer_if.master: fifo_empty/fifo_rd_en/fifo_data_out, flush,
//         m_valid/m_ready/m_data/m_keep/m_last
module fifo_word_packer #(
    parameter int FIFO_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int OUT_WIDTH  = FIFO_WIDTH * PACK
) (
    input  logic               clk,
    input  logic               rst,
    fifo_word_packer_if.master bus
);
    localparam int            CW       = $clog2(PACK + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(PACK);

    logic [PACK-1:0][FIFO_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            inflight_q;
    logic                            flush_pend_q, flush_pend_d;
    logic                            m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0]            m_data_q, m_data_d;
    logic [PACK-1:0]                 m_keep_q, m_keep_d;
    logic                            m_last_q, m_last_d;

    logic          rd_en;
    logic          out_free;
    logic          xfer;
    logic [CW-1:0] base;

    // The byte already in flight owns a lane, so it is counted before issuing another pop.
    assign rd_en = !bus.fifo_empty && !flush_pend_q && ((cnt_q + CW'(inflight_q)) < CNT_FULL);

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;

        // Output register can take a new word when empty or being drained this cycle.
        out_free = !m_valid_q || bus.m_ready;
        xfer     = out_free &&
                   ((cnt_q == CNT_FULL) || (flush_pend_q && !inflight_q && (cnt_q != '0)));

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        if (xfer) begin
            m_valid_d = 1'b1;
            m_last_d  = flush_pend_q;
            for (int i = 0; i < PACK; i++) begin
                m_keep_d[i] = (CW'(i) < cnt_q);
                m_data_d[i*FIFO_WIDTH +: FIFO_WIDTH] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
            end
        end

        // A byte arriving while the word leaves becomes lane 0 of the next word.
        base  = xfer ? '0 : cnt_q;
        cnt_d = base + CW'(inflight_q);
        if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (CW'(i) == base) begin
                    acc_d[i] = bus.fifo_data_out;
                end
            end
        end

        // A pending flush retires when its word leaves, or at once if nothing is held.
        if (flush_pend_q) begin
            if (xfer || ((cnt_q == '0) && !inflight_q)) begin
                flush_pend_d = 1'b0;
            end
        end else begin
            flush_pend_d = bus.flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            inflight_q   <= rd_en;
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_keep     = m_keep_q;
    assign bus.m_last     = m_last_q;
endmodule
